// File: rtl/somador_pkg.sv
// Shared definitions for the full-adder self-test.
//   bist_state_t : sequencer states
//   NUM_VECTORS  : size of the exhaustive {a,b,c} sweep
//   golden()     : reference full adder, returns {soma, vaium}
package somador_pkg;

    localparam int unsigned NUM_VECTORS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCheck,
        StDone
    } bist_state_t;

    function automatic logic [1:0] golden(input logic a, input logic b, input logic c);
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

endpackage

// File: rtl/somador_bist_if.sv
// Bundle between the self-test engine and its environment.
//   master : the BIST engine (drives a/b/c and status, receives start and adder outputs)
//   slave  : the environment (drives start and the adder outputs, observes status)
interface somador_bist_if #(
    parameter int unsigned ERR_W = 32
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             saida1;
    logic             saida2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] errors;
    logic [2:0]       first_fail;
    logic [2:0]       vectornum;

    modport master (
        input  start, saida1, saida2,
        output a, b, c, busy, done, pass, errors, first_fail, vectornum
    );

    modport slave (
        output start, saida1, saida2,
        input  a, b, c, busy, done, pass, errors, first_fail, vectornum
    );
endinterface

// File: rtl/somador_ref.sv
// Combinational golden full adder used by the self-test engine.
//   a, b, c : operand bits (c is carry-in)
//   soma    : expected sum
//   vaium   : expected carry-out
module somador_ref
    import somador_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic soma,
    output logic vaium
);
    assign {soma, vaium} = golden(a, b, c);
endmodule

// File: rtl/somador_bist.sv
// On-chip stimulus generator and response checker for the 1-bit full adder.
// Sweeps all {a,b,c} combinations N_PASSES times, compares the adder outputs
// with a golden model and reports a saturating error count.
//   clk, reset : clock and asynchronous active-high reset
//   bus.start  : run request (honoured only when idle or done)
//   bus.a/b/c  : stimulus to the adder; bus.saida1/saida2 : adder sum/carry
//   bus.busy, bus.done, bus.pass, bus.errors, bus.first_fail, bus.vectornum : status
module somador_bist
    import somador_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned N_PASSES      = 1,
    parameter int unsigned ERR_W         = 32
) (
    input logic            clk,
    input logic            reset,
    somador_bist_if.master bus
);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    bist_state_t      state_q;
    logic [SW-1:0]    settle_q;
    logic [PW-1:0]    pass_cnt_q;
    logic             a_q, b_q, c_q;
    logic             busy_q, done_q, pass_q;
    logic [ERR_W-1:0] errors_q;
    logic [2:0]       first_fail_q;
    logic [2:0]       vectornum_q;

    logic             soma, vaium, mismatch;
    logic [ERR_W-1:0] errors_inc;

    somador_ref u_ref (
        .a     (a_q),
        .b     (b_q),
        .c     (c_q),
        .soma  (soma),
        .vaium (vaium)
    );

    assign mismatch   = (bus.saida1 != soma) || (bus.saida2 != vaium);
    // Saturate rather than wrap so a heavy failure never reads as a pass.
    assign errors_inc = (&errors_q) ? errors_q : errors_q + ERR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            pass_cnt_q   <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            c_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            errors_q     <= '0;
            first_fail_q <= '0;
            vectornum_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        errors_q     <= '0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                        done_q       <= 1'b0;
                        vectornum_q  <= '0;
                        pass_cnt_q   <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= StApply;
                    end
                end
                StApply: begin
                    {a_q, b_q, c_q} <= vectornum_q;
                    settle_q        <= SW'(SETTLE_CYCLES - 1);
                    state_q         <= StSettle;
                end
                StSettle: begin
                    if (settle_q == '0) begin
                        state_q <= StCheck;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        errors_q <= errors_inc;
                        // errors_q never returns to zero within a run, so zero means "first".
                        if (errors_q == '0) begin
                            first_fail_q <= {a_q, b_q, c_q};
                        end
                    end
                    if (vectornum_q != 3'(NUM_VECTORS - 1)) begin
                        vectornum_q <= vectornum_q + 3'd1;
                        state_q     <= StApply;
                    end else if (pass_cnt_q != PW'(N_PASSES - 1)) begin
                        vectornum_q <= '0;
                        pass_cnt_q  <= pass_cnt_q + PW'(1);
                        state_q     <= StApply;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mismatch && (errors_q == '0);
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.c          = c_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.errors     = errors_q;
    assign bus.first_fail = first_fail_q;
    assign bus.vectornum  = vectornum_q;

endmodule

// File: tb/tb_somador_bist.sv
module tb_somador_bist;

    typedef struct {
        int errors;
        int first_fail;
        int pass;
        int latency;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   st_cyc[3];
    int   fm[3];              // adder fault: 0 good, 1 saida2 stuck 0, 2 saida1 inverted
    exp_t q0[$], q1[$], q2[$];
    logic [2:0] done_prev = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    somador_bist_if #(.ERR_W(32)) if0 ();
    somador_bist_if #(.ERR_W(32)) if1 ();
    somador_bist_if #(.ERR_W(2))  if2 ();

    somador_bist #(.SETTLE_CYCLES(1), .N_PASSES(1), .ERR_W(32)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.master));
    somador_bist #(.SETTLE_CYCLES(1), .N_PASSES(2), .ERR_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.master));
    somador_bist #(.SETTLE_CYCLES(1), .N_PASSES(1), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.master));

    // Adder under test, written independently of the RTL golden function.
    function automatic logic [1:0] adder(input logic a, input logic b, input logic c,
                                         input int f);
        logic s, co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        if (f == 1) co = 1'b0;
        if (f == 2) s = ~s;
        return {s, co};
    endfunction

    always_comb begin
        {if0.saida1, if0.saida2} = adder(if0.a, if0.b, if0.c, fm[0]);
        {if1.saida1, if1.saida2} = adder(if1.a, if1.b, if1.c, fm[1]);
        {if2.saida1, if2.saida2} = adder(if2.a, if2.b, if2.c, fm[2]);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_run(input string tag, input exp_t e, input int err, input int ff,
                               input int ps, input int bz, input int lat);
        check({tag, "_errors"}, err, e.errors);
        check({tag, "_first_fail"}, ff, e.first_fail);
        check({tag, "_pass"}, ps, e.pass);
        check({tag, "_busy"}, bz, 0);
        check({tag, "_latency"}, lat, e.latency);
    endtask

    // Monitor: pops an expectation on each rising done.
    always @(negedge clk) begin
        if (if0.done && !done_prev[0]) begin
            if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
            else compare_run("dut0", q0.pop_front(), 32'(if0.errors), 32'(if0.first_fail),
                             32'(if0.pass), 32'(if0.busy), cyc - st_cyc[0]);
        end
        if (if1.done && !done_prev[1]) begin
            if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
            else compare_run("dut1", q1.pop_front(), 32'(if1.errors), 32'(if1.first_fail),
                             32'(if1.pass), 32'(if1.busy), cyc - st_cyc[1]);
        end
        if (if2.done && !done_prev[2]) begin
            if (q2.size() == 0) check("dut2_unexpected_done", 1, 0);
            else compare_run("dut2", q2.pop_front(), 32'(if2.errors), 32'(if2.first_fail),
                             32'(if2.pass), 32'(if2.busy), cyc - st_cyc[2]);
        end
        done_prev <= {if2.done, if1.done, if0.done};
    end

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       if0.start = v;
            1:       if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    // One-cycle start pulse; optionally records the sampling edge for latency.
    task automatic pulse_start(input int id, input bit record);
        @(negedge clk);
        set_start(id, 1'b1);
        @(posedge clk);
        #1;
        if (record) st_cyc[id] = cyc;
        set_start(id, 1'b0);
    endtask

    task automatic wait_drain(input int id, input int budget, input string name);
        int n = 0;
        while (qsize(id) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, qsize(id), 0);
        @(negedge clk);
    endtask

    task automatic wait_vec0(input int v, input int budget, input string name);
        int n = 0;
        while (32'(if0.vectornum) != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_vec_timeout"}, 32'(if0.vectornum), v);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_abc"}, 32'({if0.a, if0.b, if0.c}), 0);
        check({tag, "_busy"}, 32'(if0.busy), 0);
        check({tag, "_done"}, 32'(if0.done), 0);
        check({tag, "_pass"}, 32'(if0.pass), 0);
        check({tag, "_errors"}, 32'(if0.errors), 0);
        check({tag, "_first_fail"}, 32'(if0.first_fail), 0);
        check({tag, "_vectornum"}, 32'(if0.vectornum), 0);
    endtask

    initial begin
        fm[0] = 0; fm[1] = 0; fm[2] = 0;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero0("reset");
        reset = 1'b0;

        // Good adder: pass, 24 cycles.
        q0.push_back('{errors: 0, first_fail: 0, pass: 1, latency: 24});
        pulse_start(0, 1'b1);
        wait_drain(0, 60, "good");

        // Carry stuck at 0: vectors 011,101,110,111 fail. Start from DONE clears done.
        fm[0] = 1;
        q0.push_back('{errors: 4, first_fail: 3, pass: 0, latency: 24});
        pulse_start(0, 1'b1);
        check("restart_done_cleared", 32'(if0.done), 0);
        check("restart_busy_set", 32'(if0.busy), 1);
        wait_drain(0, 60, "carry0");

        // Start re-pulsed while busy is ignored.
        fm[0] = 0;
        q0.push_back('{errors: 0, first_fail: 0, pass: 1, latency: 24});
        pulse_start(0, 1'b1);
        wait_vec0(3, 40, "ignore");
        pulse_start(0, 1'b0);
        wait_drain(0, 60, "ignore");

        // Reset mid-run aborts to reset values; a fresh run then passes.
        fm[0] = 1;
        q0.push_back('{errors: 4, first_fail: 3, pass: 0, latency: 24});
        pulse_start(0, 1'b1);
        wait_vec0(5, 40, "abort");
        reset = 1'b1;
        #1;
        check_zero0("abort");
        q0.delete();
        @(negedge clk);
        reset = 1'b0;
        fm[0] = 0;
        q0.push_back('{errors: 0, first_fail: 0, pass: 1, latency: 24});
        pulse_start(0, 1'b1);
        wait_drain(0, 60, "fresh");

        // Two passes with inverted sum: every vector fails twice.
        fm[1] = 2;
        q1.push_back('{errors: 16, first_fail: 0, pass: 0, latency: 48});
        pulse_start(1, 1'b1);
        wait_drain(1, 100, "two_pass");

        // 2-bit counter saturates at 3.
        fm[2] = 2;
        q2.push_back('{errors: 3, first_fail: 0, pass: 0, latency: 24});
        pulse_start(2, 1'b1);
        wait_drain(2, 60, "saturate");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
